alu_seq: RTL

Parametrised, handshaked successor to the 8-bit combinational ALU, for use in datapath exercises. It accepts one operation at a time over a valid/ready interface. Simple ops complete in one cycle; multiply, and optionally divide, run iteratively over WIDTH cycles. Results and flags are registered and held until the consumer takes them.

---
 rtl/alu_seq_if.sv | 28 ++
 rtl/alu_seq.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/alu_seq_if.sv
// Handshake bundle for alu_seq: request channel (a, b, opcode) and registered result channel.
interface alu_seq_if #(
   parameter int unsigned WIDTH = 8
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [3:0]       opcode;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] result;
   logic [WIDTH-1:0] result_hi;
   logic             zero;
   logic             carry;
   logic             overflow;
   logic             err;

   modport master (
      output in_valid, a, b, opcode, out_ready,
      input  in_ready, out_valid, result, result_hi, zero, carry, overflow, err
   );

   modport slave (
      input  in_valid, a, b, opcode, out_ready,
      output in_ready, out_valid, result, result_hi, zero, carry, overflow, err
   );
endinterface

// File: rtl/alu_seq.sv
// Handshaked ALU: single-cycle logic/arith ops, iterative shift-add MUL and (with ALU_DIV_EN
// defined) restoring DIV over WIDTH cycles. Results and flags are registered until taken.
module alu_seq #(
   parameter int unsigned WIDTH = 8
) (
   input logic     clk,
   input logic     rst_n,
   alu_seq_if.slave bus
);

   localparam int unsigned CW = $clog2(WIDTH + 1);

   localparam logic [3:0] OpAdd = 4'd0;
   localparam logic [3:0] OpSub = 4'd1;
   localparam logic [3:0] OpAnd = 4'd2;
   localparam logic [3:0] OpOr  = 4'd3;
   localparam logic [3:0] OpXor = 4'd4;
   localparam logic [3:0] OpNot = 4'd5;
   localparam logic [3:0] OpShl = 4'd6;
   localparam logic [3:0] OpShr = 4'd7;
   localparam logic [3:0] OpMul = 4'd8;
`ifdef ALU_DIV_EN
   localparam logic [3:0] OpDiv = 4'd9;
`endif

   typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

   state_e           state_q;
   logic [CW-1:0]    cnt_q;
   logic [WIDTH-1:0] hi_q;
   logic [WIDTH-1:0] lo_q;
   logic [WIDTH-1:0] b_q;
   logic [WIDTH-1:0] result_q;
   logic [WIDTH-1:0] result_hi_q;
   logic             zero_q;
   logic             carry_q;
   logic             overflow_q;
   logic             err_q;
`ifdef ALU_DIV_EN
   logic             is_div_q;
`endif

   // Single-cycle datapath
   logic [WIDTH:0]   add_sum;
   logic [WIDTH:0]   sub_diff;
   logic [WIDTH-1:0] s_res;
   logic             s_carry;
   logic             s_ovf;
   logic             s_err;
   logic             s_iter;
   logic             shift_oob;

   always_comb begin
      add_sum   = {1'b0, bus.a} + {1'b0, bus.b};
      sub_diff  = {1'b0, bus.a} - {1'b0, bus.b};
      shift_oob = (bus.b >= WIDTH'(WIDTH));
      s_res     = '0;
      s_carry   = 1'b0;
      s_ovf     = 1'b0;
      s_err     = 1'b0;
      s_iter    = 1'b0;
      case (bus.opcode)
         OpAdd: begin
            s_res   = add_sum[WIDTH-1:0];
            s_carry = add_sum[WIDTH];
            s_ovf   = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) &&
                      (add_sum[WIDTH-1] != bus.a[WIDTH-1]);
         end
         OpSub: begin
            s_res   = sub_diff[WIDTH-1:0];
            s_carry = sub_diff[WIDTH];
            s_ovf   = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) &&
                      (sub_diff[WIDTH-1] != bus.a[WIDTH-1]);
         end
         OpAnd: s_res = bus.a & bus.b;
         OpOr:  s_res = bus.a | bus.b;
         OpXor: s_res = bus.a ^ bus.b;
         OpNot: s_res = ~bus.a;
         OpShl: s_res = shift_oob ? '0 : (bus.a << bus.b);
         OpShr: s_res = shift_oob ? '0 : (bus.a >> bus.b);
         OpMul: s_iter = 1'b1;
`ifdef ALU_DIV_EN
         OpDiv: s_iter = 1'b1;
`endif
         default: s_err = 1'b1;
      endcase
   end

   // Iterative step: hi_q/lo_q hold {partial product, multiplier} or {remainder, quotient}
   logic [WIDTH:0]   mul_sum;
   logic [WIDTH-1:0] step_hi;
   logic [WIDTH-1:0] step_lo;
   logic             step_ovf;
   logic             step_err;
`ifdef ALU_DIV_EN
   logic [WIDTH:0]   div_sh;
   logic [WIDTH:0]   div_diff;
`endif

   always_comb begin
      mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
      step_hi  = mul_sum[WIDTH:1];
      step_lo  = {mul_sum[0], lo_q[WIDTH-1:1]};
      step_ovf = (step_hi != '0);
      step_err = 1'b0;
`ifdef ALU_DIV_EN
      div_sh   = {hi_q, lo_q[WIDTH-1]};
      div_diff = div_sh - {1'b0, b_q};
      if (is_div_q) begin
         step_ovf = 1'b0;
         step_err = (b_q == '0);
         // Divisor of zero never borrows, so quotient fills with ones and a shifts into remainder
         if (!div_diff[WIDTH]) begin
            step_hi = div_diff[WIDTH-1:0];
            step_lo = {lo_q[WIDTH-2:0], 1'b1};
         end else begin
            step_hi = div_sh[WIDTH-1:0];
            step_lo = {lo_q[WIDTH-2:0], 1'b0};
         end
      end
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         cnt_q       <= '0;
         hi_q        <= '0;
         lo_q        <= '0;
         b_q         <= '0;
         result_q    <= '0;
         result_hi_q <= '0;
         zero_q      <= 1'b0;
         carry_q     <= 1'b0;
         overflow_q  <= 1'b0;
         err_q       <= 1'b0;
`ifdef ALU_DIV_EN
         is_div_q    <= 1'b0;
`endif
      end else begin
         unique case (state_q)
            StIdle: begin
               if (bus.in_valid) begin
                  hi_q  <= '0;
                  lo_q  <= bus.a;
                  b_q   <= bus.b;
                  cnt_q <= '0;
`ifdef ALU_DIV_EN
                  is_div_q <= (bus.opcode == OpDiv);
`endif
                  if (s_iter) begin
                     state_q <= StCalc;
                  end else begin
                     state_q     <= StDone;
                     result_q    <= s_res;
                     result_hi_q <= '0;
                     zero_q      <= (s_res == '0);
                     carry_q     <= s_carry;
                     overflow_q  <= s_ovf;
                     err_q       <= s_err;
                  end
               end
            end
            StCalc: begin
               hi_q  <= step_hi;
               lo_q  <= step_lo;
               cnt_q <= cnt_q + CW'(1);
               if (cnt_q == CW'(WIDTH - 1)) begin
                  state_q     <= StDone;
                  cnt_q       <= '0;
                  result_q    <= step_lo;
                  result_hi_q <= step_hi;
                  zero_q      <= (step_lo == '0);
                  carry_q     <= 1'b0;
                  overflow_q  <= step_ovf;
                  err_q       <= step_err;
               end
            end
            StDone: begin
               if (bus.out_ready) state_q <= StIdle;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign bus.in_ready  = (state_q == StIdle);
   assign bus.out_valid = (state_q == StDone);
   assign bus.result    = result_q;
   assign bus.result_hi = result_hi_q;
   assign bus.zero      = zero_q;
   assign bus.carry     = carry_q;
   assign bus.overflow  = overflow_q;
   assign bus.err       = err_q;

endmodule
